// File: rtl/gray_to_binary_tracker.sv
// Registered Gray-to-binary decoder that classifies each sample against the previous one.
// Optional macro GRAY_TRACK_ERRCNT_EN builds the saturating illegal-jump counter on err_cnt.
module gray_to_binary_tracker #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic [1:0]       step,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam logic [1:0] STEP_HOLD  = 2'b00;
  localparam logic [1:0] STEP_UP    = 2'b01;
  localparam logic [1:0] STEP_DOWN  = 2'b10;
  localparam logic [1:0] STEP_FIRST = 2'b11;

  typedef enum logic {S_EMPTY, S_TRACK} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_prev;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_bin;
  logic [1:0]       r_step;
  logic             r_err;

  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_prev_inc;
  logic [WIDTH-1:0] w_prev_dec;
  logic             w_accept;
  logic [1:0]       w_step;
  logic             w_err;

  // Each binary bit is the XOR of all Gray bits at or above it.
  assign w_bin[WIDTH-1] = gray_in[WIDTH-1];
  generate
    for (genvar gi = WIDTH - 2; gi >= 0; gi--) begin : g_decode
      assign w_bin[gi] = w_bin[gi+1] ^ gray_in[gi];
    end
  endgenerate

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_prev_inc = r_prev + WIDTH'(1);
  assign w_prev_dec = r_prev - WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_step       = STEP_HOLD;
    w_err        = 1'b0;
    case (r_state)
      S_EMPTY: begin
        w_step = STEP_FIRST;
        if (w_accept) w_state_next = S_TRACK;
      end
      S_TRACK: begin
        if (w_bin == r_prev)          w_step = STEP_HOLD;
        else if (w_bin == w_prev_inc) w_step = STEP_UP;
        else if (w_bin == w_prev_dec) w_step = STEP_DOWN;
        else                          w_err  = 1'b1;
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  // prev follows every accepted sample, errors included, so tracking resyncs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev      <= '0;
      r_out_valid <= 1'b0;
      r_bin       <= '0;
      r_step      <= STEP_HOLD;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_prev      <= w_bin;
      r_out_valid <= 1'b1;
      r_bin       <= w_bin;
      r_step      <= w_step;
      r_err       <= w_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef GRAY_TRACK_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

  assign out_valid = r_out_valid;
  assign bin_out   = r_bin;
  assign step      = r_step;
  assign err       = r_err;

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Directed bench for gray_to_binary_tracker with a cycle-level reference model.
// Follows GRAY_TRACK_ERRCNT_EN so the same file covers both counter builds.
module tb_gray_to_binary_tracker;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] gray_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] bin_out;
  logic [1:0]   step;
  logic         err;
  logic [7:0]   err_cnt;

  int tests = 0;
  int fails = 0;

  gray_to_binary_tracker #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .gray_in  (gray_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bin_out  (bin_out),
    .step     (step),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_decode(input int g);
    int b = 0;
    for (int k = 0; k < W; k++) b = b ^ (g >> k);
    return b % MOD;
  endfunction

  bit m_valid, m_have_prev, m_err;
  int m_prev, m_bin, m_step, m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 0; m_have_prev = 0; m_err = 0;
      m_prev = 0; m_bin = 0; m_step = 0; m_cnt = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_bin = m_decode(int'(gray_in));
      m_err = 0;
      if (!m_have_prev)                        m_step = 3;
      else if (m_bin == m_prev)                m_step = 0;
      else if (m_bin == (m_prev + 1) % MOD)    m_step = 1;
      else if (m_bin == (m_prev + MOD - 1) % MOD) m_step = 2;
      else begin m_step = 0; m_err = 1; end
`ifdef GRAY_TRACK_ERRCNT_EN
      if (m_err && m_cnt < 255) m_cnt = m_cnt + 1;
`endif
      m_prev = m_bin; m_have_prev = 1; m_valid = 1;
    end else if (out_ready) begin
      m_valid = 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("cyc_out_valid", int'(out_valid), int'(m_valid));
      check("cyc_in_ready", int'(in_ready), int'(!m_valid || out_ready));
      check("cyc_err_cnt", int'(err_cnt), m_cnt);
      if (m_valid) begin
        check("cyc_bin", int'(bin_out), m_bin);
        check("cyc_step", int'(step), m_step);
        check("cyc_err", int'(err), int'(m_err));
      end
    end
  end

  task automatic send(input logic [W-1:0] g);
    in_valid = 1'b1;
    gray_in  = g;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("[TB] gray=%b -> valid=%0b bin=%0d step=%0d err=%0b err_cnt=%0d",
             g, out_valid, bin_out, step, err, err_cnt);
  endtask

  task automatic expect_out(input string name, input int b, input int s, input int e);
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_bin"}, int'(bin_out), b);
    check({name, "_step"}, int'(step), s);
    check({name, "_err"}, int'(err), e);
  endtask

  int exp_errs;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; gray_in = '0;
    exp_errs = 0;

    // Model pins: hand-decoded Gray values.
    check("model_dec_1000", m_decode(4'b1000), 15);
    check("model_dec_0110", m_decode(4'b0110), 4);
    check("model_dec_0101", m_decode(4'b0101), 6);

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_bin", int'(bin_out), 0);
    check("rst_step", int'(step), 0);
    check("rst_err", int'(err), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_in_ready", int'(in_ready), 1);
    reset = 1'b0;

    // First sample and up/down steps.
    send(4'b0000); expect_out("first", 0, 3, 0);
    send(4'b0001); expect_out("up1", 1, 1, 0);
    send(4'b0011); expect_out("up2", 2, 1, 0);
    send(4'b0001); expect_out("down1", 1, 2, 0);

    // Wrap-around (1 -> 15 is itself an illegal jump).
    send(4'b1000); expect_out("jump15", 15, 0, 1); exp_errs++;
    send(4'b0000); expect_out("wrap_up", 0, 1, 0);
    send(4'b1000); expect_out("wrap_down", 15, 2, 0);

    // Illegal jump then resync.
    send(4'b0000); expect_out("to0", 0, 1, 0);
    send(4'b0011); expect_out("illegal", 2, 0, 1); exp_errs++;
`ifdef GRAY_TRACK_ERRCNT_EN
    check("illegal_cnt", int'(err_cnt), exp_errs);
`else
    check("illegal_cnt_off", int'(err_cnt), 0);
`endif
    send(4'b0010); expect_out("resync", 3, 1, 0);

    // Backpressure: drain+accept, then stall for 5 cycles with a sample waiting.
    send(4'b0110); expect_out("bp_first", 4, 1, 0);
    out_ready = 1'b0; in_valid = 1'b1; gray_in = 4'b0111;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_in_ready", int'(in_ready), 0);
      expect_out("bp_hold", 4, 1, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_out("bp_replace", 5, 1, 0);
    @(posedge clk); #1;
    check("bp_drained", int'(out_valid), 0);

    // Asynchronous reset with a pending output.
    out_ready = 1'b0;
    send(4'b0000); expect_out("pre_rst", 0, 0, 1); exp_errs++;
    #3 reset = 1'b1;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_err_cnt", int'(err_cnt), 0);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    send(4'b0101); expect_out("post_rst", 6, 3, 0);

    // 300 back-to-back illegal jumps (0 <-> 8).
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      gray_in = (i % 2 == 0) ? 4'b0000 : 4'b1100;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
`ifdef GRAY_TRACK_ERRCNT_EN
    check("storm_sat", int'(err_cnt), 255);
`else
    check("storm_off", int'(err_cnt), 0);
`endif

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
